// File: rtl/vdp_pkg.sv
// Shared VDP definitions: register-bus widths and the register-write record
// passed between the copper, host decode and the register file.
package vdp_pkg;
   localparam int VDP_REG_ADDR_WIDTH = 6;
   localparam int VDP_REG_DATA_WIDTH = 16;

   typedef struct packed {
      logic [VDP_REG_ADDR_WIDTH-1:0] address;
      logic [VDP_REG_DATA_WIDTH-1:0] data;
   } vdp_reg_write_t;
endpackage

// File: rtl/vdp_reg_write_fifo.sv
// Synchronous FIFO of register writes. The head entry is held in a register
// so it can be presented the cycle after it becomes the head.
module vdp_reg_write_fifo
   import vdp_pkg::*;
#(
   parameter  int FIFO_DEPTH = 4,
   localparam int PTR_W      = $clog2(FIFO_DEPTH),
   localparam int CNT_W      = PTR_W + 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           push,
   input  vdp_reg_write_t push_data,
   input  logic           pop,
   input  logic           flush,
   output vdp_reg_write_t head,
   output logic           full,
   output logic           empty,
   output logic [CNT_W-1:0] count
);
   vdp_reg_write_t   mem [FIFO_DEPTH];
   vdp_reg_write_t   head_reg;
   logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic             do_push, do_pop;

   assign full  = (count_reg == CNT_W'(FIFO_DEPTH));
   assign empty = (count_reg == '0);
   assign count = count_reg;
   assign head  = head_reg;

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_pop      = pop && !empty;
   assign do_push     = push && !flush && (!full || do_pop);
   assign rd_ptr_next = do_pop ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;

   always_comb begin
      count_next = count_reg;
      if (do_push && !do_pop)
         count_next = count_reg + CNT_W'(1);
      else if (!do_push && do_pop)
         count_next = count_reg - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         rd_ptr_reg <= rd_ptr_next;
         if (do_push)
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         count_reg <= count_next;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr_reg] <= push_data;
   end

   // Next head comes from the incoming write when it lands in the head slot.
   always_ff @(posedge clk) begin
      if (do_push && (wr_ptr_reg == rd_ptr_next))
         head_reg <= push_data;
      else
         head_reg <= mem[rd_ptr_next];
   end
endmodule

// File: rtl/vdp_reg_write_arbiter.sv
// Merges buffered copper register writes with priority host writes into the
// single VDP register-file write port.
module vdp_reg_write_arbiter
   import vdp_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          copper_enable,
   input  logic [VDP_REG_ADDR_WIDTH-1:0] copper_write_address,
   input  logic [VDP_REG_DATA_WIDTH-1:0] copper_write_data,
   input  logic                          copper_write_en,
   output logic                          copper_write_ready,
   input  logic [VDP_REG_ADDR_WIDTH-1:0] host_write_address,
   input  logic [VDP_REG_DATA_WIDTH-1:0] host_write_data,
   input  logic                          host_write_en,
   output logic [VDP_REG_ADDR_WIDTH-1:0] reg_write_address,
   output logic [VDP_REG_DATA_WIDTH-1:0] reg_write_data,
   output logic                          reg_write_en,
   output logic                          overflow,
   input  logic                          overflow_clear
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   vdp_reg_write_t   fifo_head, copper_entry;
   logic             fifo_full, fifo_empty, fifo_pop, push_req, push_accept, drop;
   logic [CNT_W-1:0] fifo_count, count_next, free_next;

   assign copper_entry = '{address: copper_write_address, data: copper_write_data};

   assign fifo_pop    = !host_write_en && !fifo_empty;
   assign push_req    = copper_write_en && copper_enable;
   assign push_accept = push_req && (!fifo_full || fifo_pop);
   assign drop        = push_req && fifo_full && !fifo_pop;

   // Occupancy after this edge, used so ready reflects the state the copper sees next.
   assign count_next = !copper_enable ? '0
                     : fifo_count + CNT_W'(push_accept) - CNT_W'(fifo_pop);
   assign free_next  = CNT_W'(FIFO_DEPTH) - count_next;

   vdp_reg_write_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_req),
      .push_data (copper_entry),
      .pop       (fifo_pop),
      .flush     (!copper_enable),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         reg_write_en       <= 1'b0;
         reg_write_address  <= '0;
         reg_write_data     <= '0;
         copper_write_ready <= 1'b1;
         overflow           <= 1'b0;
      end else begin
         reg_write_en <= host_write_en || fifo_pop;
         if (host_write_en) begin
            reg_write_address <= host_write_address;
            reg_write_data    <= host_write_data;
         end else if (fifo_pop) begin
            reg_write_address <= fifo_head.address;
            reg_write_data    <= fifo_head.data;
         end
         copper_write_ready <= (free_next >= CNT_W'(2));
         if (drop)
            overflow <= 1'b1;
         else if (overflow_clear)
            overflow <= 1'b0;
      end
   end
endmodule

// File: tb/tb_vdp_reg_write_arbiter.sv
// Scoreboard bench: a queue-based reference model predicts register-file writes
// and ready/overflow per cycle; a monitor compares them against the DUT.
module tb_vdp_reg_write_arbiter;
   import vdp_pkg::*;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        copper_enable = 1'b1;
   logic [5:0]  copper_write_address = '0;
   logic [15:0] copper_write_data = '0;
   logic        copper_write_en = 1'b0;
   logic        copper_write_ready;
   logic [5:0]  host_write_address = '0;
   logic [15:0] host_write_data = '0;
   logic        host_write_en = 1'b0;
   logic [5:0]  reg_write_address;
   logic [15:0] reg_write_data;
   logic        reg_write_en;
   logic        overflow;
   logic        overflow_clear = 1'b0;

   always #5 clk = ~clk;

   vdp_reg_write_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
      .clk                  (clk),
      .reset                (reset),
      .copper_enable        (copper_enable),
      .copper_write_address (copper_write_address),
      .copper_write_data    (copper_write_data),
      .copper_write_en      (copper_write_en),
      .copper_write_ready   (copper_write_ready),
      .host_write_address   (host_write_address),
      .host_write_data      (host_write_data),
      .host_write_en        (host_write_en),
      .reg_write_address    (reg_write_address),
      .reg_write_data       (reg_write_data),
      .reg_write_en         (reg_write_en),
      .overflow             (overflow),
      .overflow_clear       (overflow_clear)
   );

   typedef struct { int cyc; logic [5:0] a; logic [15:0] d; } wr_t;
   typedef struct { int cyc; logic rdy; logic ovf; } st_t;

   wr_t         wq[$];
   st_t         sq[$];
   logic [21:0] mq[$];
   logic        m_ovf = 1'b0;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Drive one cycle of stimulus and record what the model predicts for the next cycle.
   task automatic step(input logic rst, input logic cen, input logic cwe,
                       input logic [5:0] ca, input logic [15:0] cd,
                       input logic hwe, input logic [5:0] ha, input logic [15:0] hd,
                       input logic oclr);
      logic [21:0] e;
      logic        dropped;
      @(posedge clk);
      #2;
      reset = rst; copper_enable = cen; copper_write_en = cwe;
      copper_write_address = ca; copper_write_data = cd;
      host_write_en = hwe; host_write_address = ha; host_write_data = hd;
      overflow_clear = oclr;
      if (rst) begin
         mq.delete();
         m_ovf = 1'b0;
      end else begin
         if (hwe)
            wq.push_back('{cyc + 1, ha, hd});
         else if (mq.size() > 0) begin
            e = mq.pop_front();
            wq.push_back('{cyc + 1, e[21:16], e[15:0]});
         end
         dropped = 1'b0;
         if (!cen)
            mq.delete();
         else if (cwe) begin
            if (mq.size() < DEPTH) mq.push_back({ca, cd});
            else dropped = 1'b1;
         end
         if (dropped) m_ovf = 1'b1;
         else if (oclr) m_ovf = 1'b0;
      end
      sq.push_back('{cyc + 1, (DEPTH - mq.size()) >= 2, m_ovf});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 1, 0, 6'h0, 16'h0, 0, 6'h0, 16'h0, 0);
   endtask

   initial begin : monitor
      wr_t w;
      st_t s;
      forever begin
         @(negedge clk);
         while (wq.size() > 0 && wq[0].cyc < cyc) begin
            w = wq.pop_front();
            n_cmp++; n_bad++;
            $display("FAIL write_late cyc=%0d expected addr=%h data=%h at cyc %0d, not seen", cyc, w.a, w.d, w.cyc);
         end
         if (reg_write_en === 1'b1) begin
            n_cmp++;
            if (wq.size() > 0 && wq[0].cyc == cyc) begin
               w = wq.pop_front();
               if (reg_write_address !== w.a || reg_write_data !== w.d) begin
                  n_bad++;
                  $display("FAIL write_value cyc=%0d got addr=%h data=%h want addr=%h data=%h",
                           cyc, reg_write_address, reg_write_data, w.a, w.d);
               end else
                  $display("cyc=%0d write addr=%h data=%h ok", cyc, w.a, w.d);
            end else begin
               n_bad++;
               $display("FAIL write_unexpected cyc=%0d got addr=%h data=%h want no write",
                        cyc, reg_write_address, reg_write_data);
            end
         end else if (wq.size() > 0 && wq[0].cyc == cyc) begin
            w = wq.pop_front();
            n_cmp++; n_bad++;
            $display("FAIL write_missing cyc=%0d got en=%b want addr=%h data=%h", cyc, reg_write_en, w.a, w.d);
         end
         if (sq.size() > 0 && sq[0].cyc == cyc) begin
            s = sq.pop_front();
            n_cmp++;
            if (copper_write_ready !== s.rdy || overflow !== s.ovf) begin
               n_bad++;
               $display("FAIL status cyc=%0d got ready=%b overflow=%b want ready=%b overflow=%b",
                        cyc, copper_write_ready, overflow, s.rdy, s.ovf);
            end
         end
      end
   end

   initial begin : driver
      step(1, 1, 0, 6'h0, 16'h0, 0, 6'h0, 16'h0, 0);
      step(1, 1, 0, 6'h0, 16'h0, 0, 6'h0, 16'h0, 0);
      idle(3);
      // host only
      step(0, 1, 0, 6'h0, 16'h0, 1, 6'h05, 16'h1234, 0);
      idle(3);
      // copper only
      step(0, 1, 1, 6'h10, 16'hAAAA, 0, 6'h0, 16'h0, 0);
      idle(3);
      // contention
      step(0, 1, 1, 6'h02, 16'h0002, 1, 6'h01, 16'h0001, 0);
      idle(3);
      // back-pressure: copper and host every cycle, fifth copper write drops
      for (int i = 0; i < 6; i++)
         step(0, 1, 1, 6'(8'h20 + i), 16'(16'hB000 + i), 1, 6'(8'h30 + i), 16'(16'hC000 + i), 0);
      idle(6);
      step(0, 1, 0, 6'h0, 16'h0, 0, 6'h0, 16'h0, 1);
      idle(2);
      // flush with three entries buffered
      for (int i = 0; i < 3; i++)
         step(0, 1, 1, 6'(8'h08 + i), 16'(16'hF000 + i), 1, 6'h3F, 16'(16'hE000 + i), 0);
      step(0, 0, 1, 6'h0B, 16'hF003, 0, 6'h0, 16'h0, 0);
      idle(4);
      // reset mid-drain
      for (int i = 0; i < 2; i++)
         step(0, 1, 1, 6'(8'h18 + i), 16'(16'hD000 + i), 1, 6'h3E, 16'(16'hD100 + i), 0);
      step(1, 1, 0, 6'h0, 16'h0, 0, 6'h0, 16'h0, 0);
      idle(4);
      // randomized traffic
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 199) == 0,
              $urandom_range(0, 19) != 0,
              $urandom_range(0, 1) == 1,
              6'($urandom), 16'($urandom),
              $urandom_range(0, 9) < 3,
              6'($urandom), 16'($urandom),
              $urandom_range(0, 19) == 0);
      idle(10);
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (wq.size() != 0 || sq.size() != 0) begin
         n_bad++;
         $display("FAIL drain_end got %0d writes %0d status pending want 0 0", wq.size(), sq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/vdp_reg_write_arbiter.md
# vdp_reg_write_arbiter

Sink for the VDP register-write bus. It merges copper-issued register writes with host CPU register writes into the single write port of the VDP register file. Copper writes are buffered in a small FIFO and back-pressured through `copper_write_ready`. Host writes always take priority and are never dropped. The block sits between `vdp_copper`/host bus decode and the VDP register file.

## Interface
- `FIFO_DEPTH`, 4: copper write buffer entries; power of two, ≥ 4.
- `clk`  in  1  VDP clock.
- `reset`  in  1  synchronous, active-high reset.
- `copper_enable`  in  1  copper run enable; low flushes the buffer.
- `copper_write_address`  in  6  copper target register.
- `copper_write_data`  in  16  copper write data.
- `copper_write_en`  in  1  one-cycle write pulse; issued regardless of ready.
- `copper_write_ready`  out  1  registered; high = at least 2 free entries.
- `host_write_address`  in  6  host target register.
- `host_write_data`  in  16  host write data.
- `host_write_en`  in  1  one-cycle host write pulse.
- `reg_write_address`  out  6  register file address, registered.
- `reg_write_data`  out  16  register file data, registered.
- `reg_write_en`  out  1  register file write strobe, registered.
- `overflow`  out  1  sticky; a copper write was dropped.
- `overflow_clear`  in  1  clears `overflow`.

## Operation
- Each cycle, exactly one source may drive the output:
  - If `host_write_en`: output the host write.
  - Else if the FIFO is non-empty: pop the head and output it.
  - Else `reg_write_en` is 0.
- Copper push: when `copper_write_en` and `copper_enable`, push `{address, data}` into the FIFO.
- No bypass path: a copper write always passes through the FIFO.
- Push and pop in the same cycle: count is unchanged, pointers both advance.
- Push when full and no pop: the write is dropped and `overflow` is set. Push when full with a same-cycle pop is accepted.
- `copper_write_ready` is registered as `(FIFO_DEPTH - count_next) >= 2`. The slack covers the one-cycle lag seen by a copper writing every cycle.
- `copper_enable` low: the FIFO is flushed (count, rd_ptr and wr_ptr set to 0) and pushes are ignored. Host writes are unaffected.
- Same-cycle flush and pop: the pop still outputs the head entry that cycle.
- `overflow`: set on a drop, cleared by `overflow_clear`. If both happen in the same cycle, set wins.
- No address filtering. Ordering is preserved among copper writes and among host writes; there is no ordering between the two sources.

## Timing
- Reset values: `reg_write_en` 0, `reg_write_address` 0, `reg_write_data` 0, `copper_write_ready` 1, `overflow` 0; FIFO empty.
- Host write at cycle N: `reg_write_en` high at N+1.
- Copper write at N with FIFO empty and no host write at N+1: entry is visible at N+1 and output at N+2 (2-cycle latency).
- Each host write delays FIFO drain by one cycle.
- Count width is `$clog2(FIFO_DEPTH)+1`; pointers wrap modulo `FIFO_DEPTH`.
- Reset mid-operation discards all buffered writes within one cycle.

## Structure
- Shared package `vdp_pkg`:
  - `VDP_REG_ADDR_WIDTH` = 6
  - `VDP_REG_DATA_WIDTH` = 16
  - packed struct type `vdp_reg_write_t` {address, data}
- Sub-module `vdp_reg_write_fifo`:
  - synchronous FIFO of `vdp_reg_write_t`
  - ports: push, pop, flush, full, empty, count
  - read data is the registered head entry
- The arbiter keeps the output registers, priority select, ready and overflow logic.

## Test plan
- Host only: host writes addr 0x05 / data 0x1234 at cycle 10 -> `reg_write_en`=1, addr 0x05, data 0x1234 at cycle 11 only.
- Copper only: copper writes 0x10/0xAAAA at cycle 5 -> output at cycle 7; `overflow` stays 0.
- Contention: host 0x01/0x0001 and copper 0x02/0x0002 both at cycle 3 -> host output at 4, copper output at 5.
- Back-pressure: copper writes every cycle while host writes every cycle (DEPTH 4) -> `copper_write_ready` falls at count ≥ 3; after 5 pushes, `overflow`=1 and exactly 4 entries later drain in order.
- Flush: 3 entries buffered, `copper_enable` low for 1 cycle -> at most the current head is output, the rest are discarded, and `copper_write_ready`=1 next cycle.
- Reset mid-drain: reset asserted with 2 entries buffered -> next cycle `reg_write_en`=0, FIFO empty, `overflow`=0.
